axi_lite_mem_slave: RTL and testbench
=====================================

# axi_lite_mem_slave

Synthesizable AXI-Lite slave memory that sits directly downstream of the core's instruction and data bus interface units (ibiu/dbiu). It accepts single-beat AXI-Lite reads and writes, services them from an internal word array with a programmable read latency, and returns OKAY/SLVERR responses. It replaces the behavioural slave driver so subsystem-level simulation, and later FPGA bring-up, run against real handshake logic. Contents are preloaded through hierarchical access to `mem`.

## Interface
- ADDR_WIDTH, 64, byte address width
- DATA_WIDTH, 64, data width; fixed at 64 (8 byte strobes)
- DEPTH_LOG2, 19, log2 of word count (2^19 x 64-bit = 4 MiB)
- RD_LAT, 1, cycles from AR handshake to rvalid; legal 1..15
- clk  in  1  core clock; only clock
- rst_n  in  1  asynchronous, active-low reset
- awvalid / awready  in/out  1  write-address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- wvalid / wready  in/out  1  write-data handshake
- wdata  in  64  write data
- wstrb  in  8  byte enables
- bvalid / bready  out/in  1  write-response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid / arready  in/out  1  read-address handshake
- araddr  in  ADDR_WIDTH  read byte address
- rvalid / rready  out/in  1  read-data handshake
- rdata  out  64  read data
- rresp  out  2  00 OKAY, 10 SLVERR

## Operation
- Word index = addr[DEPTH_LOG2+2:3]; addr[2:0] ignored. Address in range iff addr[ADDR_WIDTH-1:DEPTH_LOG2+3] == 0.
- Write FSM: W_IDLE, W_RESP.
  - W_IDLE: awready = !aw_held, wready = !w_held. AW and W are latched independently, in either order or the same cycle.
  - On the edge where both are held: if in range, the array is written bytewise per wstrb; else no write. bresp is set to OKAY or SLVERR, held flags clear, state goes to W_RESP.
  - W_RESP: bvalid=1, awready=wready=0. On bvalid&&bready, return to W_IDLE.
- Read FSM: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready=1. On handshake, latch index and range flag, load counter with RD_LAT-1, then go to R_WAIT, or directly to R_RESP if RD_LAT==1.
  - R_WAIT: counter decrements; leave at 0.
  - On entering R_RESP, rdata is registered from the array (0 if out of range), and rresp is set to OKAY or SLVERR.
  - R_RESP: rvalid=1 and arready=0. rdata and rresp stay stable until rvalid&&rready, then return to R_IDLE.
- One outstanding transaction per channel. Read and write channels are fully independent.
- Read/write collision on the same word at the same edge: the read captures the pre-write contents; a write committed on any earlier edge is visible.
- The array is not reset.

## Timing
- Reset values: awready=wready=arready=0 while rst_n=0. After release: arready=1, awready=1, wready=1 in the first cycle. bvalid=rvalid=0, rdata=0, bresp=rresp=00.
- Read: AR handshake in cycle N gives rvalid high in cycle N+RD_LAT. Back-to-back reads occur at a rate of one per RD_LAT+1 cycles when rready is held high.
- Write: last of AW/W handshakes in cycle N gives array update and bvalid in cycle N+1. A new AW can be accepted in the cycle after the B handshake.
- rready/bready low: response is held indefinitely, and no new AR/AW is accepted.
- Reset asserted mid-transaction: all FSMs return to idle asynchronously and held AW/W are discarded. An uncommitted write never reaches the array, and no response is issued for dropped transactions.

## Test plan
- Preload mem[0x10]=0x1122334455667788; AR 0x80, RD_LAT=1, rready=1 -> rvalid in cycle N+1, rdata=0x1122334455667788, rresp=00.
- Write wdata=0xAAAA_BBBB_CCCC_DDDD, wstrb=0x0F to 0x80 over the preload above, then read 0x80 -> bresp=00, rdata=0x11223344CCCCDDDD.
- W presented 3 cycles before AW (address 0x100, data 0x5, strobe 0xFF) -> wready drops after the W handshake; bvalid comes one cycle after the AW handshake; the read returns 0x5.
- AR at 1<<(DEPTH_LOG2+3), RD_LAT=4 -> rvalid at N+4, rdata=0, rresp=10. AW to the same address -> bresp=10 and memory is unchanged.
- RD_LAT=2, rready held low 5 cycles -> rvalid and rdata stable; arready=0 throughout; the second AR is accepted the cycle after the handshake.
- Same-edge collision: read of 0x80 (old 0x1) enters R_RESP on the same edge a write of 0x2 commits -> rdata=0x1; a subsequent read returns 0x2.
- Assert rst_n for 1 cycle after the AW handshake and before the W handshake -> no bvalid; memory unchanged; after release all readys=1.

Source files
------------

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite single-beat memory slave: independent write and read FSMs over a
// 64-bit word array, with a programmable read latency and OKAY/SLVERR responses.
module axi_lite_mem_slave #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH_LOG2 = 19,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  output logic [1:0]              bresp_o,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [3:0] RD_LAT_M1   = 4'(RD_LAT - 1);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'b00, R_WAIT = 2'b01, R_RESP = 2'b10} r_state_e;

  logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  aw_inr_q, aw_inr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  aw_hs_s, w_hs_s, commit_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic                  wr_inr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [STRB_W-1:0]     wr_strb_s;

  r_state_e              r_state_q, r_state_d;
  logic [IDX_W-1:0]      ar_idx_q, ar_idx_d;
  logic                  ar_inr_q, ar_inr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q, rresp_d;
  logic                  ar_hs_s, rd_load_s, rd_inr_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  unused_addr_lsbs_s;

  assign unused_addr_lsbs_s = ^{awaddr_i[2:0], araddr_i[2:0]};

  assign awready_o = rst_n && (w_state_q == W_IDLE) && !aw_held_q;
  assign wready_o  = rst_n && (w_state_q == W_IDLE) && !w_held_q;
  assign aw_hs_s   = awvalid_i && awready_o;
  assign w_hs_s    = wvalid_i && wready_o;
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bresp_o   = bresp_q;

  assign arready_o = rst_n && (r_state_q == R_IDLE);
  assign ar_hs_s   = arvalid_i && arready_o;
  assign rvalid_o  = (r_state_q == R_RESP);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;

  // Write FSM next state; a beat arriving this cycle bypasses its holding register
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    aw_inr_d  = aw_inr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit_s  = 1'b0;
    wr_idx_s  = aw_hs_s ? awaddr_i[DEPTH_LOG2+2:3] : aw_idx_q;
    wr_inr_s  = aw_hs_s ? ~|awaddr_i[ADDR_WIDTH-1:DEPTH_LOG2+3] : aw_inr_q;
    wr_data_s = w_hs_s ? wdata_i : wdata_q;
    wr_strb_s = w_hs_s ? wstrb_i : wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_held_d = 1'b1;
          aw_idx_d  = wr_idx_s;
          aw_inr_d  = wr_inr_s;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (w_hs_s) begin
          w_held_d = 1'b1;
          wdata_d  = wdata_i;
          wstrb_d  = wstrb_i;
        end else begin
          w_held_d = w_held_q;
        end
        if ((aw_held_q || aw_hs_s) && (w_held_q || w_hs_s)) begin
          commit_s  = 1'b1;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = wr_inr_s ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (bready_i) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-channel registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= {IDX_W{1'b0}};
      aw_inr_q  <= 1'b0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= {STRB_W{1'b0}};
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_inr_q  <= aw_inr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Array update: byte lanes per strobe; the array itself is never reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (commit_s && wr_inr_s && wr_strb_s[b]) begin
        mem[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
      end
    end
  end

  // Read FSM next state; rdata is loaded on the edge that enters R_RESP
  always_comb begin
    r_state_d = r_state_q;
    ar_idx_d  = ar_idx_q;
    ar_inr_d  = ar_inr_q;
    cnt_d     = cnt_q;
    rresp_d   = rresp_q;
    rd_load_s = 1'b0;
    rd_idx_s  = ar_idx_q;
    rd_inr_s  = ar_inr_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          ar_idx_d = araddr_i[DEPTH_LOG2+2:3];
          ar_inr_d = ~|araddr_i[ADDR_WIDTH-1:DEPTH_LOG2+3];
          cnt_d    = RD_LAT_M1;
          if (RD_LAT <= 1) begin
            r_state_d = R_RESP;
            rd_load_s = 1'b1;
            rd_idx_s  = ar_idx_d;
            rd_inr_s  = ar_inr_d;
          end else begin
            r_state_d = R_WAIT;
          end
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d     = 4'd0;
          r_state_d = R_RESP;
          rd_load_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (rready_i) begin
          r_state_d = R_IDLE;
        end else begin
          r_state_d = R_RESP;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_load_s) begin
      rresp_d = rd_inr_s ? RESP_OKAY : RESP_SLVERR;
    end else begin
      rresp_d = rresp_q;
    end
  end

  // Read-channel registers, including the registered response data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      ar_idx_q  <= {IDX_W{1'b0}};
      ar_inr_q  <= 1'b0;
      cnt_q     <= 4'd0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state_q <= r_state_d;
      ar_idx_q  <= ar_idx_d;
      ar_inr_q  <= ar_inr_d;
      cnt_q     <= cnt_d;
      rresp_q   <= rresp_d;
      if (rd_load_s) begin
        rdata_q <= rd_inr_s ? mem[rd_idx_s] : {DATA_WIDTH{1'b0}};
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed bench for axi_lite_mem_slave: three instances with RD_LAT of 1, 2 and 4.
module tb_axi_lite_mem_slave;
  localparam int N = 3;
  localparam logic [63:0] OOR_ADDR = 64'h0000_0000_0040_0000;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] awvalid, awready, wvalid, wready, bvalid, bready;
  logic [N-1:0] arvalid, arready, rvalid, rready;
  logic [63:0] awaddr [N];
  logic [63:0] wdata  [N];
  logic [63:0] araddr [N];
  logic [63:0] rdata  [N];
  logic [7:0]  wstrb  [N];
  logic [1:0]  bresp  [N];
  logic [1:0]  rresp  [N];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    axi_lite_mem_slave #(.RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid_i(awvalid[g]), .awready_o(awready[g]), .awaddr_i(awaddr[g]),
      .wvalid_i(wvalid[g]), .wready_o(wready[g]), .wdata_i(wdata[g]), .wstrb_i(wstrb[g]),
      .bvalid_o(bvalid[g]), .bready_i(bready[g]), .bresp_o(bresp[g]),
      .arvalid_i(arvalid[g]), .arready_o(arready[g]), .araddr_i(araddr[g]),
      .rvalid_o(rvalid[g]), .rready_i(rready[g]), .rdata_o(rdata[g]), .rresp_o(rresp[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int k, input logic [63:0] addr, input int lat,
                    input logic [63:0] exp_d, input logic [1:0] exp_r, input string tag);
    int n;
    arvalid[k] = 1'b1;
    araddr[k]  = addr;
    chk({tag, "_arready"}, 64'(arready[k]), 64'd1);
    tick();
    arvalid[k] = 1'b0;
    n = 1;
    while (!rvalid[k] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_rdata"}, rdata[k], exp_d);
    chk({tag, "_rresp"}, 64'(rresp[k]), 64'(exp_r));
    tick();
    chk({tag, "_rdone"}, 64'(rvalid[k]), 64'd0);
  endtask

  task automatic wr(input int k, input logic [63:0] addr, input logic [63:0] data,
                    input logic [7:0] strb, input logic [1:0] exp_r, input string tag);
    awvalid[k] = 1'b1; awaddr[k] = addr;
    wvalid[k]  = 1'b1; wdata[k]  = data; wstrb[k] = strb;
    chk({tag, "_awready"}, 64'(awready[k] & wready[k]), 64'd1);
    tick();
    awvalid[k] = 1'b0;
    wvalid[k]  = 1'b0;
    chk({tag, "_bvalid"}, 64'(bvalid[k]), 64'd1);
    chk({tag, "_bresp"}, 64'(bresp[k]), 64'(exp_r));
    tick();
    chk({tag, "_bdone"}, 64'(bvalid[k]), 64'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready  = '1; rready = '1;
    for (int i = 0; i < N; i++) begin
      awaddr[i] = 64'd0; wdata[i] = 64'd0; araddr[i] = 64'd0; wstrb[i] = 8'd0;
    end
    g_dut[0].u_dut.mem[16] = 64'h1122_3344_5566_7788;
    g_dut[0].u_dut.mem[17] = 64'h0;
    g_dut[0].u_dut.mem[32] = 64'h0;
    g_dut[1].u_dut.mem[2]  = 64'hCAFE_F00D_0000_0002;
    g_dut[1].u_dut.mem[3]  = 64'hCAFE_F00D_0000_0003;
    g_dut[2].u_dut.mem[0]  = 64'h0123_4567_89AB_CDEF;
    repeat (2) tick();

    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_readys", 64'({awready, wready, arready}), 64'h1FF);
    chk("rel_valids", 64'({bvalid, rvalid}), 64'd0);
    chk("rel_rdata", rdata[0], 64'd0);
    chk("rel_resps", 64'({bresp[0], rresp[0]}), 64'd0);
    tick();

    rd(0, 64'h80, 1, 64'h1122_3344_5566_7788, 2'b00, "rd_preload");
    wr(0, 64'h80, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 2'b00, "wr_strb");
    rd(0, 64'h80, 1, 64'h1122_3344_CCCC_DDDD, 2'b00, "rd_strb");

    wvalid[0] = 1'b1; wdata[0] = 64'h5; wstrb[0] = 8'hFF;
    chk("wfirst_wready", 64'(wready[0]), 64'd1);
    tick();
    wvalid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wfirst_held", 64'({wready[0], awready[0], bvalid[0]}), 64'b010);
      if (i < 2) tick();
    end
    awvalid[0] = 1'b1; awaddr[0] = 64'h100;
    tick();
    awvalid[0] = 1'b0;
    chk("wfirst_bvalid", 64'(bvalid[0]), 64'd1);
    chk("wfirst_bresp", 64'(bresp[0]), 64'd0);
    tick();
    rd(0, 64'h100, 1, 64'h5, 2'b00, "wfirst_rd");

    rd(2, OOR_ADDR, 4, 64'd0, 2'b10, "oor_rd");
    wr(2, OOR_ADDR, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10, "oor_wr");
    rd(2, 64'h0, 4, 64'h0123_4567_89AB_CDEF, 2'b00, "oor_mem");

    rready[1] = 1'b0;
    arvalid[1] = 1'b1; araddr[1] = 64'h10;
    tick();
    araddr[1] = 64'h18;
    chk("stall_n1", 64'({rvalid[1], arready[1]}), 64'd0);
    tick();
    chk("stall_rvalid", 64'(rvalid[1]), 64'd1);
    chk("stall_rdata", rdata[1], 64'hCAFE_F00D_0000_0002);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", 64'({rvalid[1], arready[1], rresp[1]}), 64'b1000);
      chk("stall_rdata_hold", rdata[1], 64'hCAFE_F00D_0000_0002);
    end
    rready[1] = 1'b1;
    tick();
    chk("stall_after_hs", 64'({rvalid[1], arready[1]}), 64'b01);
    tick();
    arvalid[1] = 1'b0;
    chk("stall_ar2_n1", 64'(rvalid[1]), 64'd0);
    tick();
    chk("stall_ar2_rvalid", 64'(rvalid[1]), 64'd1);
    chk("stall_ar2_rdata", rdata[1], 64'hCAFE_F00D_0000_0003);
    tick();

    wr(0, 64'h80, 64'h1, 8'hFF, 2'b00, "coll_pre");
    arvalid[0] = 1'b1; araddr[0] = 64'h80;
    awvalid[0] = 1'b1; awaddr[0] = 64'h80;
    wvalid[0]  = 1'b1; wdata[0]  = 64'h2; wstrb[0] = 8'hFF;
    tick();
    arvalid[0] = 1'b0; awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    chk("coll_valids", 64'({rvalid[0], bvalid[0]}), 64'b11);
    chk("coll_old", rdata[0], 64'h1);
    tick();
    rd(0, 64'h80, 1, 64'h2, 2'b00, "coll_new");

    awvalid[0] = 1'b1; awaddr[0] = 64'h80;
    tick();
    awvalid[0] = 1'b0;
    chk("rstmid_held", 64'({awready[0], bvalid[0]}), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_readys", 64'({awready, wready, arready}), 64'd0);
    tick();
    chk("rstmid_bvalid", 64'(bvalid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rstmid_rel", 64'({awready, wready, arready}), 64'h1FF);
    tick();
    wvalid[0] = 1'b1; wdata[0] = 64'h3; wstrb[0] = 8'hFF;
    tick();
    wvalid[0] = 1'b0;
    chk("rstmid_aw_dropped", 64'({bvalid[0], wready[0]}), 64'd0);
    awvalid[0] = 1'b1; awaddr[0] = 64'h88;
    tick();
    awvalid[0] = 1'b0;
    chk("rstmid_bvalid2", 64'(bvalid[0]), 64'd1);
    tick();
    rd(0, 64'h80, 1, 64'h2, 2'b00, "rstmid_unchanged");
    rd(0, 64'h88, 1, 64'h3, 2'b00, "rstmid_new");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
